// File: rtl/abro_fsm.sv
// abro_fsm: four-state one-hot Moore detector for the A, then B, then A&B sequence.
// O rises once A has been seen, then B, then both together. It holds while either
// input stays high and re-arms once both inputs drop. The state register is also
// brought out on a port for debug and for external checks.
module abro_fsm (
   input  logic       clk,
   input  logic       reset_n,   // active-high synchronous reset despite the suffix
   input  logic       A,
   input  logic       B,
   output logic       O,
   output logic [3:0] state
);

   // One-hot encodings; the values are fixed because the state is visible externally.
   typedef enum logic [3:0] {
      IDLE    = 4'b0001,
      STATE_A = 4'b0010,
      STATE_B = 4'b0100,
      STATE_O = 4'b1000
   } state_e;

   // Kept as a plain vector so corrupted (non-one-hot) values stay representable.
   logic [3:0] state_reg;

   // State register: reset wins, then one transition at most per edge;
   // any non-one-hot value falls back to IDLE.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         state_reg <= IDLE;
      end else begin
         case (state_reg)
            IDLE:    state_reg <= A         ? STATE_A : IDLE;
            STATE_A: state_reg <= B         ? STATE_B : STATE_A;
            STATE_B: state_reg <= (A && B)  ? STATE_O : STATE_B;
            STATE_O: state_reg <= (!A && !B) ? IDLE   : STATE_O;
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Moore decode from the state register only, so A/B never reach O combinationally.
   always_comb begin
      O = (state_reg == STATE_O);
   end

   assign state = state_reg;

endmodule

// File: tb/tb_abro_fsm.sv
// tb_abro_fsm: directed-vector bench for abro_fsm with hand-computed expectations.
`timescale 1ns/1ps
module tb_abro_fsm;

   logic       clk;
   logic       reset_n;
   logic       A;
   logic       B;
   logic       O;
   logic [3:0] state;

   int vectors;
   int miscompares;

   abro_fsm dut (
      .clk     (clk),
      .reset_n (reset_n),
      .A       (A),
      .B       (B),
      .O       (O),
      .state   (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply inputs at the falling edge, let one rising edge pass, and settle 1 ns.
   task automatic step(input logic r, input logic a, input logic b);
      @(negedge clk);
      reset_n = r;
      A = a;
      B = b;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(1'b1, 1'b0, 1'b0);
      vectors++;
      if (state !== 4'b0001 || O !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_edge: state=%b O=%b, expected state=0001 O=0", state, O);
      end
      else $display("reset_edge: state=%b O=%b", state, O);
      step(1'b0, 1'b0, 1'b0);
      vectors++;
      if (state !== 4'b0001 || O !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle: state=%b O=%b, expected state=0001 O=0", state, O);
      end
      else $display("reset_idle: state=%b O=%b", state, O);
   endtask

   task automatic test_full_sequence();
      logic [1:0] ab  [5] = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b00};
      logic [3:0] exs [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0001};
      logic       exo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 5; i++) begin
         step(1'b0, ab[i][1], ab[i][0]);
         vectors++;
         if (state !== exs[i] || O !== exo[i]) begin
            miscompares++;
            $display("FAIL full_seq[%0d] A=%b B=%b: state=%b O=%b, expected state=%b O=%b",
                     i, ab[i][1], ab[i][0], state, O, exs[i], exo[i]);
         end
         else $display("full_seq[%0d] A=%b B=%b: state=%b O=%b", i, ab[i][1], ab[i][0], state, O);
      end
   endtask

   task automatic test_holds();
      // Starts in IDLE: B alone is ignored, A advances, then the hold cases in each state.
      logic [1:0] ab  [12] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00,
                               2'b11, 2'b10, 2'b01, 2'b00};
      logic [3:0] exs [12] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100,
                               4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b0001};
      for (int i = 0; i < 12; i++) begin
         step(1'b0, ab[i][1], ab[i][0]);
         vectors++;
         if (state !== exs[i] || O !== (exs[i] == 4'b1000)) begin
            miscompares++;
            $display("FAIL holds[%0d] A=%b B=%b: state=%b O=%b, expected state=%b O=%b",
                     i, ab[i][1], ab[i][0], state, O, exs[i], (exs[i] == 4'b1000));
         end
         else $display("holds[%0d] A=%b B=%b: state=%b O=%b", i, ab[i][1], ab[i][0], state, O);
      end
   endtask

   task automatic test_simultaneous();
      logic [3:0] exs [3] = '{4'b0010, 4'b0100, 4'b1000};
      logic       exo [3] = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b1);
         vectors++;
         if (state !== exs[i] || O !== exo[i]) begin
            miscompares++;
            $display("FAIL simultaneous[%0d]: state=%b O=%b, expected state=%b O=%b",
                     i, state, O, exs[i], exo[i]);
         end
         else $display("simultaneous[%0d]: state=%b O=%b", i, state, O);
      end
   endtask

   task automatic test_reset_mid();
      // Entered in STATE_O from the previous scenario.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 1'b1);
         vectors++;
         if (state !== 4'b0001 || O !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid[%0d]: state=%b O=%b, expected state=0001 O=0", i, state, O);
         end
         else $display("reset_mid[%0d]: state=%b O=%b", i, state, O);
      end
      step(1'b0, 1'b1, 1'b0);
      vectors++;
      if (state !== 4'b0010 || O !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release: state=%b O=%b, expected state=0010 O=0", state, O);
      end
      else $display("reset_release: state=%b O=%b", state, O);
   endtask

   task automatic test_illegal_state();
      @(negedge clk);
      reset_n = 1'b0;
      A = 1'b1;
      B = 1'b1;
      force dut.state_reg = 4'b0110;
      #1;
      vectors++;
      if (state !== 4'b0110 || O !== 1'b0) begin
         miscompares++;
         $display("FAIL illegal_forced: state=%b O=%b, expected state=0110 O=0", state, O);
      end
      else $display("illegal_forced: state=%b O=%b", state, O);
      release dut.state_reg;
      @(posedge clk);
      #1;
      vectors++;
      if (state !== 4'b0001 || O !== 1'b0) begin
         miscompares++;
         $display("FAIL illegal_recover: state=%b O=%b, expected state=0001 O=0", state, O);
      end
      else $display("illegal_recover: state=%b O=%b", state, O);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset_n     = 1'b0;
      A           = 1'b0;
      B           = 1'b0;
      test_reset();
      test_full_sequence();
      test_holds();
      test_simultaneous();
      test_reset_mid();
      test_illegal_state();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/abro_fsm.md
Name: abro_fsm

Overview:
- Four-state Moore sequence detector with one-hot state encoding, single clock domain.
- Asserts O after this input sequence:
  - A is seen.
  - Then B is seen.
  - Then A and B are high together.
- Holds O until both inputs drop, then re-arms.
- Exposes its state register for debug and for checks by the surrounding control logic.

Parameters:
- None. State encoding is fixed: IDLE=4'b0001, STATE_A=4'b0010, STATE_B=4'b0100, STATE_O=4'b1000.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- reset_n  input  1  reset, synchronous and active-high. The port is asserted when 1, despite the _n suffix.
- A  input  1  event input A, sampled on rising clk.
- B  input  1  event input B, sampled on rising clk.
- O  output  1  detection output; 1 exactly when state==STATE_O.
- state  output  4  current one-hot state register value.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: on a rising clk edge with reset_n=1, state <= IDLE (4'b0001) and O=0.
  - Reset overrides all transitions.
  - Reset mid-sequence, including in STATE_O, returns to IDLE on that edge.
- O is a Moore output, decoded combinationally from the state register only. No combinational path from A/B to O or state.
- Latency: input values present before an edge take effect in state and O right after that edge (one cycle).
- Transitions, evaluated each rising edge when not in reset:
  - IDLE: A=1 -> STATE_A (B ignored); A=0 -> stay IDLE.
  - STATE_A: B=1 -> STATE_B (A ignored); B=0 -> stay STATE_A.
  - STATE_B: A=1 and B=1 -> STATE_O; any other combination -> stay STATE_B.
  - STATE_O: A=0 and B=0 -> IDLE; any other combination -> stay STATE_O, O held 1.
- Simultaneous A=1,B=1 in IDLE -> STATE_A only. States are never skipped; at most one transition per cycle.
- Illegal or non-one-hot state values (e.g. after an SEU) -> next state IDLE, O=0.
- Outputs have no X after the first reset edge. Before the first reset, the state value is undefined.

Test Plan:
- Reset: hold reset_n=1 for one edge, then 0. With A=0,B=0 for one cycle -> state=4'b0001, O=0.
- Full sequence from IDLE, one cycle each:
  - A=1,B=0 -> state=4'b0010, O=0.
  - A=0,B=1 -> state=4'b0100, O=0.
  - A=1,B=1 -> state=4'b1000, O=1.
  - A=0,B=0 -> state=4'b0001, O=0.
  - A=0,B=0 -> stays 4'b0001, O=0.
- Holds:
  - In STATE_A with A=1,B=0 for 3 cycles -> state stays 4'b0010.
  - In STATE_B with A=1,B=0 -> stays 4'b0100.
  - In STATE_O with A=1,B=0 -> stays 4'b1000, O=1.
- Simultaneous inputs: A=1,B=1 from IDLE -> 4'b0010, then 4'b0100 next cycle, then 4'b1000. O=1 only at the third edge.
- Reset mid-operation: reach STATE_O, assert reset_n=1 with A=1,B=1 -> next edge state=4'b0001, O=0. Remains IDLE while reset is held.
- Illegal state: force state register to 4'b0110 -> next edge state=4'b0001, O=0.
